// File: rtl/scenery_scroller.sv
// Scrolls roadside scenery slots down once per frame, respawning above the screen (SCENERY_RANDOM_X_EN adds random respawn X).
// Latency: slot i settles i+1 cycles after startOfFrame; newLevel/levelUp settle at OBJ_COUNT+1.
// Backpressure: none; startOfFrame is ignored while busy, and a paused frame is skipped.
module scenery_scroller #(
    parameter int OBJ_COUNT  = 4,
    parameter int SCREEN_H   = 480,
    parameter int OBJ_H      = 64,
    parameter int LEFT_X     = 16,
    parameter int RIGHT_X    = 560,
    parameter int LEVEL_DIST = 20000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    startOfFrame,
    input  logic [3:0]              speed,
    input  logic                    pause,
    output logic [OBJ_COUNT*11-1:0] objX,
    output logic [OBJ_COUNT*11-1:0] objY,
    output logic [OBJ_COUNT-1:0]    objKind,
    output logic                    newLevel,
    output logic                    levelUp,
    output logic                    busy
);
    localparam int IDXW = (OBJ_COUNT > 1) ? $clog2(OBJ_COUNT) : 1;
    localparam logic signed [10:0] SCREEN_H_S   = 11'(SCREEN_H);
    localparam logic signed [10:0] NEG_OBJ_H    = 11'(-OBJ_H);
    localparam logic signed [10:0] LEFT_X_S     = 11'(LEFT_X);
    localparam logic signed [10:0] RIGHT_X_S    = 11'(RIGHT_X);
    localparam logic [16:0]        LEVEL_DIST_W = 17'(LEVEL_DIST);

    typedef enum logic [1:0] {S_IDLE, S_UPD, S_DIST} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  w_upd_en;
    logic                  w_dist_en;
    logic [IDXW-1:0]       r_idx;
    logic signed [10:0]    r_y [OBJ_COUNT];
    logic signed [10:0]    r_x [OBJ_COUNT];
    logic [OBJ_COUNT-1:0]  r_kind;
    logic [15:0]           r_lfsr;
    logic [15:0]           r_dist;
    logic                  r_new_level;
    logic                  r_level_up;
    logic signed [10:0]    w_ny;
    logic signed [10:0]    w_resp_y;
    logic signed [10:0]    w_base_x;
    logic signed [10:0]    w_resp_x;
    logic                  w_wrap;
    logic                  w_last;
    logic [16:0]           w_dist_sum;
    logic                  w_level_hit;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (startOfFrame && !pause) w_next_state = S_UPD;
            S_UPD:   if (w_last) w_next_state = S_DIST;
            S_DIST:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != S_IDLE);
        w_upd_en  = (r_state == S_UPD);
        w_dist_en = (r_state == S_DIST);
    end

    assign w_last   = (r_idx == IDXW'(OBJ_COUNT - 1));
    assign w_ny     = r_y[r_idx] + $signed({7'd0, speed});
    assign w_wrap   = (w_ny >= SCREEN_H_S);
    // Respawn gap of 0..63 lines above the -OBJ_H line staggers re-entering objects.
    assign w_resp_y = NEG_OBJ_H - $signed({5'd0, r_lfsr[5:0]});
    assign w_base_x = r_idx[0] ? RIGHT_X_S : LEFT_X_S;
`ifdef SCENERY_RANDOM_X_EN
    assign w_resp_x = w_base_x + $signed({6'd0, r_lfsr[9:6], 1'b0});
`else
    assign w_resp_x = w_base_x;
`endif

    assign w_dist_sum  = {1'b0, r_dist} + {13'd0, speed};
    assign w_level_hit = (w_dist_sum >= LEVEL_DIST_W);

    always_ff @(posedge clk) begin
        if (reset) r_lfsr <= 16'hACE1;
        else       r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < OBJ_COUNT; i++) begin
                r_y[i] <= 11'(i * (SCREEN_H / OBJ_COUNT));
                r_x[i] <= (i % 2 == 1) ? RIGHT_X_S : LEFT_X_S;
            end
            r_kind      <= '0;
            r_idx       <= '0;
            r_dist      <= '0;
            r_new_level <= 1'b0;
            r_level_up  <= 1'b0;
        end else begin
            r_level_up <= 1'b0;
            if (r_state == S_IDLE) r_idx <= '0;
            if (w_upd_en) begin
                if (w_wrap) begin
                    r_y[r_idx]    <= w_resp_y;
                    r_x[r_idx]    <= w_resp_x;
                    r_kind[r_idx] <= r_lfsr[10];
                end else begin
                    r_y[r_idx] <= w_ny;
                end
                r_idx <= r_idx + IDXW'(1);
            end
            if (w_dist_en) begin
                if (w_level_hit) begin
                    r_dist      <= '0;
                    r_new_level <= ~r_new_level;
                    r_level_up  <= 1'b1;
                end else begin
                    r_dist <= w_dist_sum[15:0];
                end
            end
        end
    end

    for (genvar g = 0; g < OBJ_COUNT; g++) begin : g_pack
        assign objX[g*11 +: 11] = r_x[g];
        assign objY[g*11 +: 11] = r_y[g];
    end
    assign objKind  = r_kind;
    assign newLevel = r_new_level;
    assign levelUp  = r_level_up;
endmodule

// File: tb/tb_scenery_scroller.sv
// Directed bench for scenery_scroller: reset, frame latency, busy/pause, mid-frame reset, level toggle, wrap.
module tb_scenery_scroller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startOfFrame = 1'b0;
    logic [3:0]  speed = 4'd0;
    logic        pause = 1'b0;
    logic [43:0] objX;
    logic [43:0] objY;
    logic [3:0]  objKind;
    logic        newLevel;
    logic        levelUp;
    logic        busy;

    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;
    int          lu_cnt = 0;
    logic [15:0] m_lfsr = 16'hACE1;

    always #5 clk = ~clk;

    scenery_scroller #(.LEVEL_DIST(100)) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .speed(speed), .pause(pause),
        .objX(objX), .objY(objY), .objKind(objKind), .newLevel(newLevel), .levelUp(levelUp), .busy(busy)
    );

    // Reference Galois LFSR, taps 16'hB400, held at 16'hACE1 during reset.
    always @(posedge clk)
        m_lfsr <= reset ? 16'hACE1 : ({1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000));

    always @(negedge clk) if (levelUp === 1'b1) lu_cnt++;

    function automatic logic signed [10:0] gy(input int i);
        return $signed(objY[i*11 +: 11]);
    endfunction

    function automatic logic signed [10:0] gx(input int i);
        return $signed(objX[i*11 +: 11]);
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_y%0d", tag, i), gy(i), i * 120);
            chk($sformatf("%s_x%0d", tag, i), gx(i), (i % 2 == 1) ? 560 : 16);
        end
        chk({tag, "_kind"}, objKind, 0);
        chk({tag, "_newLevel"}, newLevel, 0);
        chk({tag, "_levelUp"}, levelUp, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic chk_ys(input string tag, input int y0, input int y1, input int y2, input int y3);
        chk({tag, "_y0"}, gy(0), y0);
        chk({tag, "_y1"}, gy(1), y1);
        chk({tag, "_y2"}, gy(2), y2);
        chk({tag, "_y3"}, gy(3), y3);
    endtask

    // One frame: pulse at a negedge, then observe 7 negedges. l3 is the LFSR value the
    // last slot's update uses (held between edges E+3 and E+4).
    task automatic do_frame(input logic [3:0] spd, input logic pz, output int bcnt, output logic [15:0] l3);
        @(negedge clk);
        speed = spd; pause = pz; startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0; pause = 1'b0;
        bcnt = 0; l3 = '0;
        for (int k = 0; k < 7; k++) begin
            if (busy === 1'b1) bcnt++;
            if (k == 3) l3 = m_lfsr;
            @(negedge clk);
        end
    endtask

    initial begin
        int          bcnt;
        int          lu_base;
        int          yexp;
        logic [15:0] l3;

        // Reset
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        reset = 1'b0;

        // One frame at speed 4: per-slot latency
        @(negedge clk);
        speed = 4'd4; startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        chk("f1_busy_e0", busy, 1);
        chk("f1_y0_e0", gy(0), 0);
        @(negedge clk);
        chk("f1_y0_e1", gy(0), 4);
        chk("f1_y1_e1", gy(1), 120);
        repeat (3) @(negedge clk);
        chk("f1_y3_e4", gy(3), 364);
        chk("f1_busy_e4", busy, 1);
        @(negedge clk);
        chk("f1_busy_e5", busy, 0);
        chk("f1_newLevel", newLevel, 0);
        chk("f1_levelUp", levelUp, 0);

        // Second startOfFrame while busy is ignored
        @(negedge clk);
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        bcnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (busy === 1'b1) bcnt++;
            if (k == 2) startOfFrame = 1'b1;
            if (k == 3) startOfFrame = 1'b0;
            @(negedge clk);
        end
        chk("busyign_cycles", bcnt, 5);
        chk_ys("busyign", 8, 128, 248, 368);

        // Paused frame does nothing
        do_frame(4'd4, 1'b1, bcnt, l3);
        chk("pause_busy", bcnt, 0);
        chk_ys("pause", 8, 128, 248, 368);

        // Reset while updating slot 2
        @(negedge clk);
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_y0_pre", gy(0), 12);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_state("midrst");
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk_ys("midrst_idle", 0, 120, 240, 360);
        chk("midrst_idle_busy", busy, 0);

        // Level toggle: LEVEL_DIST=100, speed 10
        lu_base = lu_cnt;
        for (int f = 1; f <= 20; f++) begin
            do_frame(4'd10, 1'b0, bcnt, l3);
            if (f == 1) chk("lvl_busy_cycles", bcnt, 5);
            chk($sformatf("lvl_newLevel_f%0d", f), newLevel, (f >= 10 && f < 20) ? 1 : 0);
            if (f == 10) begin
                chk("lvl_pulses_f10", lu_cnt - lu_base, 1);
                chk("lvl_y0_f10", gy(0), 100);
            end
        end
        chk("lvl_pulses_f20", lu_cnt - lu_base, 2);

        // Wrap of slot 3 from 476
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int f = 0; f < 29; f++) do_frame(4'd4, 1'b0, bcnt, l3);
        chk("wrap_pre_y3", gy(3), 476);
        chk("wrap_pre_y2", gy(2), 356);
        do_frame(4'd4, 1'b0, bcnt, l3);
        yexp = -64 - int'(l3[5:0]);
        chk("wrap_y3", gy(3), yexp);
        chk("wrap_y3_range", (gy(3) >= -127 && gy(3) <= -64) ? 1 : 0, 1);
        chk("wrap_kind3", objKind[3], l3[10]);
        chk("wrap_x3", gx(3), 560);
        chk("wrap_y2", gy(2), 360);
        chk("wrap_y0", gy(0), 120);
        chk("wrap_kind0", objKind[0], 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
